// File: rtl/writeback_arbiter_pkg.sv
// Shared widths, bank encodings and the writeback entry layout for the writeback arbiter.
// Optional operand forwarding is enabled by defining WB_BYPASS_EN.
package writeback_arbiter_pkg;

  localparam int WIDTH        = 16;
  localparam int REG_SEL      = 4;
  localparam int PRED_REG_SEL = 2;

  localparam logic S_REGS = 1'b0;
  localparam logic P_REGS = 1'b1;

  // One pending register-bank write: {sel, addr, data}
  typedef struct packed {
    logic               sel;
    logic [REG_SEL-1:0] addr;
    logic [WIDTH-1:0]   data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of ALU/LSU result inputs, register-bank write outputs and status for the writeback arbiter.
// Forwarding ports exist only when WB_BYPASS_EN is defined.
interface writeback_arbiter_if
  import writeback_arbiter_pkg::*;
#(
  parameter int LSU_FIFO_DEPTH = 4
);
  localparam int PW = $clog2(LSU_FIFO_DEPTH) + 1;

  // ALU results carry only alu_valid and are always taken. LSU results use
  // valid/ready: a transfer happens on a rising clk edge where lsu_valid and
  // lsu_ready are both high; lsu_ready depends only on internal state.
  logic               alu_valid;
  logic [REG_SEL-1:0] alu_addr;
  logic               alu_sel;
  logic [WIDTH-1:0]   alu_data;

  logic               lsu_valid;
  logic               lsu_ready;
  logic [REG_SEL-1:0] lsu_addr;
  logic               lsu_sel;
  logic [WIDTH-1:0]   lsu_data;

  logic               write_enable;
  logic [REG_SEL-1:0] addr_z;
  logic               z_regbank_sel;
  logic [WIDTH-1:0]   data_z;

  logic               stall_req;
  logic [PW-1:0]      lsu_pending;
  logic               protocol_err;

`ifdef WB_BYPASS_EN
  logic [REG_SEL-1:0] byp_addr_a;
  logic [REG_SEL-1:0] byp_addr_b;
  logic               byp_sel_a;
  logic               byp_sel_b;
  logic               byp_hit_a;
  logic               byp_hit_b;
  logic [WIDTH-1:0]   byp_data_a;
  logic [WIDTH-1:0]   byp_data_b;
`endif

  modport master (
    output alu_valid, alu_addr, alu_sel, alu_data,
    output lsu_valid, lsu_addr, lsu_sel, lsu_data,
    input  lsu_ready,
    input  write_enable, addr_z, z_regbank_sel, data_z,
    input  stall_req, lsu_pending, protocol_err
`ifdef WB_BYPASS_EN
    ,
    output byp_addr_a, byp_addr_b, byp_sel_a, byp_sel_b,
    input  byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
`endif
  );

  modport slave (
    input  alu_valid, alu_addr, alu_sel, alu_data,
    input  lsu_valid, lsu_addr, lsu_sel, lsu_data,
    output lsu_ready,
    output write_enable, addr_z, z_regbank_sel, data_z,
    output stall_req, lsu_pending, protocol_err
`ifdef WB_BYPASS_EN
    ,
    input  byp_addr_a, byp_addr_b, byp_sel_a, byp_sel_b,
    output byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
`endif
  );

endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible combinationally.
// Pushes while full and pops while empty are ignored.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and buffered LSU results into one registered register-bank write per cycle.
// Define WB_BYPASS_EN to add combinational forwarding of the committing write.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int LSU_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 3
) (
  input logic clk,
  input logic reset,
  writeback_arbiter_if.slave wb
);

  localparam int PW = $clog2(LSU_FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t          push_entry;
  wb_entry_t          head_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [PW-1:0]      fifo_count;

  logic               we_q;
  logic [REG_SEL-1:0] addr_q;
  logic               sel_q;
  logic [WIDTH-1:0]   data_q;
  logic [SW-1:0]      starve_q;
  logic               perr_q;
  logic               stall;

  assign push_entry = '{sel: wb.lsu_sel, addr: wb.lsu_addr, data: wb.lsu_data};

  // ALU always wins, even during a stall; stall only flags misbehaving issue
  assign fifo_pop = !wb.alu_valid && !fifo_empty;
  assign stall    = (starve_q == SW'(STARVE_LIMIT));

  wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wb.lsu_valid),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= 1'b0;
      data_q   <= '0;
      starve_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      if (wb.alu_valid) begin
        we_q   <= 1'b1;
        addr_q <= wb.alu_addr;
        sel_q  <= wb.alu_sel;
        data_q <= wb.alu_data;
      end else if (!fifo_empty) begin
        we_q   <= 1'b1;
        addr_q <= head_entry.addr;
        sel_q  <= head_entry.sel;
        data_q <= head_entry.data;
      end else begin
        we_q   <= 1'b0;
      end

      // Only an ALU win over a non-empty FIFO reaches the increment branch
      if (fifo_empty || fifo_pop) starve_q <= '0;
      else if (!stall)            starve_q <= starve_q + SW'(1);

      if (wb.alu_valid && stall) perr_q <= 1'b1;
    end
  end

  assign wb.lsu_ready     = !fifo_full;
  assign wb.write_enable  = we_q;
  assign wb.addr_z        = addr_q;
  assign wb.z_regbank_sel = sel_q;
  assign wb.data_z        = data_q;
  assign wb.stall_req     = stall;
  assign wb.lsu_pending   = fifo_count;
  assign wb.protocol_err  = perr_q;

`ifdef WB_BYPASS_EN
  assign wb.byp_hit_a  = we_q && (addr_q == wb.byp_addr_a) && (sel_q == wb.byp_sel_a);
  assign wb.byp_hit_b  = we_q && (addr_q == wb.byp_addr_b) && (sel_q == wb.byp_sel_b);
  assign wb.byp_data_a = data_q;
  assign wb.byp_data_b = data_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: arbitration, latency, starvation stall,
// protocol error and async reset; forwarding checks when WB_BYPASS_EN is defined.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  writeback_arbiter_if #(.LSU_FIFO_DEPTH(4)) wb ();

  writeback_arbiter #(
    .LSU_FIFO_DEPTH (4),
    .STARVE_LIMIT   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [REG_SEL-1:0] a,
                           input logic s, input logic [WIDTH-1:0] d);
    wb.alu_valid = v;
    wb.alu_addr  = a;
    wb.alu_sel   = s;
    wb.alu_data  = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [REG_SEL-1:0] a,
                           input logic s, input logic [WIDTH-1:0] d);
    wb.lsu_valid = v;
    wb.lsu_addr  = a;
    wb.lsu_sel   = s;
    wb.lsu_data  = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input logic [REG_SEL-1:0] a,
                             input logic s, input logic [WIDTH-1:0] d);
    check({tag, ".we"},   32'(wb.write_enable),  32'd1);
    check({tag, ".addr"}, 32'(wb.addr_z),        32'(a));
    check({tag, ".sel"},  32'(wb.z_regbank_sel), 32'(s));
    check({tag, ".data"}, 32'(wb.data_z),        32'(d));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive_alu(1'b0, '0, S_REGS, '0);
    drive_lsu(1'b0, '0, S_REGS, '0);
`ifdef WB_BYPASS_EN
    wb.byp_addr_a = '0;
    wb.byp_addr_b = '0;
    wb.byp_sel_a  = S_REGS;
    wb.byp_sel_b  = S_REGS;
`endif
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst.we",      32'(wb.write_enable), 32'd0);
    check("rst.addr",    32'(wb.addr_z),       32'd0);
    check("rst.data",    32'(wb.data_z),       32'd0);
    check("rst.ready",   32'(wb.lsu_ready),    32'd1);
    check("rst.pending", 32'(wb.lsu_pending),  32'd0);
    check("rst.stall",   32'(wb.stall_req),    32'd0);
    check("rst.perr",    32'(wb.protocol_err), 32'd0);

    // 1: single ALU write, then idle holds addr/data
    drive_alu(1'b1, 4'd5, S_REGS, 16'h1234);
    tick();
    check_write("t1.alu", 4'd5, S_REGS, 16'h1234);
    drive_alu(1'b0, '0, S_REGS, '0);
    tick();
    check("t1.idle_we",   32'(wb.write_enable), 32'd0);
    check("t1.hold_addr", 32'(wb.addr_z),       32'd5);
    check("t1.hold_data", 32'(wb.data_z),       32'h1234);

    // 2: back-to-back LSU results 3,4,5 written in order, two cycles after accept
    drive_lsu(1'b1, 4'd3, S_REGS, 16'h0300);
    tick();
    check("t2.c0_we",      32'(wb.write_enable), 32'd0);
    check("t2.c0_pending", 32'(wb.lsu_pending),  32'd1);
    drive_lsu(1'b1, 4'd4, S_REGS, 16'h0400);
    tick();
    check_write("t2.w3", 4'd3, S_REGS, 16'h0300);
    check("t2.c1_pending", 32'(wb.lsu_pending), 32'd1);
    drive_lsu(1'b1, 4'd5, S_REGS, 16'h0500);
    tick();
    check_write("t2.w4", 4'd4, S_REGS, 16'h0400);
    check("t2.c2_pending", 32'(wb.lsu_pending), 32'd1);
    drive_lsu(1'b0, '0, S_REGS, '0);
    tick();
    check_write("t2.w5", 4'd5, S_REGS, 16'h0500);
    check("t2.c3_pending", 32'(wb.lsu_pending), 32'd0);
    tick();
    check("t2.idle_we", 32'(wb.write_enable), 32'd0);

    // 3: ALU every cycle while four LSU results fill the FIFO
    drive_alu(1'b1, 4'd1, S_REGS, 16'h1000);
    drive_lsu(1'b1, 4'd8, P_REGS, 16'h8000);
    tick();
    check_write("t3.a0", 4'd1, S_REGS, 16'h1000);
    check("t3.p1",     32'(wb.lsu_pending), 32'd1);
    check("t3.stall1", 32'(wb.stall_req),   32'd0);
    drive_alu(1'b1, 4'd1, S_REGS, 16'h1001);
    drive_lsu(1'b1, 4'd9, P_REGS, 16'h8001);
    tick();
    check("t3.p2",     32'(wb.lsu_pending), 32'd2);
    check("t3.stall2", 32'(wb.stall_req),   32'd0);
    drive_alu(1'b1, 4'd1, S_REGS, 16'h1002);
    drive_lsu(1'b1, 4'd10, P_REGS, 16'h8002);
    tick();
    check("t3.p3",     32'(wb.lsu_pending), 32'd3);
    check("t3.stall3", 32'(wb.stall_req),   32'd0);
    check("t3.ready3", 32'(wb.lsu_ready),   32'd1);
    drive_alu(1'b1, 4'd1, S_REGS, 16'h1003);
    drive_lsu(1'b1, 4'd11, P_REGS, 16'h8003);
    tick();
    check_write("t3.a3", 4'd1, S_REGS, 16'h1003);
    check("t3.p4",     32'(wb.lsu_pending), 32'd4);
    check("t3.ready4", 32'(wb.lsu_ready),   32'd0);
    check("t3.stall4", 32'(wb.stall_req),   32'd1);
    // honour the stall; a fifth LSU offer while full must be refused
    drive_alu(1'b0, '0, S_REGS, '0);
    drive_lsu(1'b1, 4'd12, S_REGS, 16'hDEAD);
    tick();
    check_write("t3.pop8", 4'd8, P_REGS, 16'h8000);
    check("t3.p_after",     32'(wb.lsu_pending),  32'd3);
    check("t3.stall_clear", 32'(wb.stall_req),    32'd0);
    check("t3.ready_back",  32'(wb.lsu_ready),    32'd1);
    check("t3.perr",        32'(wb.protocol_err), 32'd0);
    drive_lsu(1'b0, '0, S_REGS, '0);

    // 4: starve again, then ignore stall_req
    drive_alu(1'b1, 4'd2, S_REGS, 16'h2000);
    tick();
    check("t4.stall_a", 32'(wb.stall_req), 32'd0);
    drive_alu(1'b1, 4'd2, S_REGS, 16'h2001);
    tick();
    check("t4.stall_b", 32'(wb.stall_req), 32'd0);
    drive_alu(1'b1, 4'd2, S_REGS, 16'h2002);
    tick();
    check("t4.stall_c", 32'(wb.stall_req),    32'd1);
    check("t4.perr_c",  32'(wb.protocol_err), 32'd0);
    drive_alu(1'b1, 4'd2, S_REGS, 16'h2ABC);
    tick();
    check_write("t4.alu_kept", 4'd2, S_REGS, 16'h2ABC);
    check("t4.perr_set",   32'(wb.protocol_err), 32'd1);
    check("t4.fifo_waits", 32'(wb.lsu_pending),  32'd3);
    check("t4.stall_sat",  32'(wb.stall_req),    32'd1);
    drive_alu(1'b0, '0, S_REGS, '0);
    tick();
    check_write("t4.pop9", 4'd9, P_REGS, 16'h8001);
    check("t4.perr_sticky", 32'(wb.protocol_err), 32'd1);
    check("t4.stall_off",   32'(wb.stall_req),    32'd0);
    check("t4.pending2",    32'(wb.lsu_pending),  32'd2);
    drive_alu(1'b1, 4'd6, S_REGS, 16'h6000);
    drive_lsu(1'b1, 4'd12, S_REGS, 16'hC000);
    tick();
    check("t4.pending3",  32'(wb.lsu_pending),  32'd3);
    check("t4.perr_hold", 32'(wb.protocol_err), 32'd1);

    // 5: asynchronous reset mid-cycle with three entries buffered
    drive_alu(1'b0, '0, S_REGS, '0);
    drive_lsu(1'b0, '0, S_REGS, '0);
    #2;
    reset = 1'b1;
    #1;
    check("t5.we",      32'(wb.write_enable),  32'd0);
    check("t5.addr",    32'(wb.addr_z),        32'd0);
    check("t5.sel",     32'(wb.z_regbank_sel), 32'd0);
    check("t5.data",    32'(wb.data_z),        32'd0);
    check("t5.pending", 32'(wb.lsu_pending),   32'd0);
    check("t5.perr",    32'(wb.protocol_err),  32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t5.post_we",      32'(wb.write_enable), 32'd0);
    tick();
    check("t5.post_we2",     32'(wb.write_enable), 32'd0);
    check("t5.post_pending", 32'(wb.lsu_pending),  32'd0);
    check("t5.post_ready",   32'(wb.lsu_ready),    32'd1);

`ifdef WB_BYPASS_EN
    // 6: forwarding of the committing write
    drive_alu(1'b1, 4'd7, S_REGS, 16'h7777);
    tick();
    drive_alu(1'b0, '0, S_REGS, '0);
    wb.byp_addr_a = 4'd7;
    wb.byp_sel_a  = S_REGS;
    wb.byp_addr_b = 4'd7;
    wb.byp_sel_b  = P_REGS;
    #1;
    check("t6.hit_a",  32'(wb.byp_hit_a),  32'd1);
    check("t6.data_a", 32'(wb.byp_data_a), 32'h7777);
    check("t6.hit_b",  32'(wb.byp_hit_b),  32'd0);
    wb.byp_addr_a = 4'd6;
    #1;
    check("t6.miss_a", 32'(wb.byp_hit_a),  32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
